cnn_kernel_acc: RTL

Multi-channel MAC kernel for the CNN accelerator core. It multiplies a KY×KX input-feature window by a KY×KX weight window once per accepted beat, and accumulates CI consecutive beats (input channels) into one result. It then adds a per-output bias, applies optional ReLU, and saturates to an output width. It is the next generation of the single-channel kernel: it adds signed/unsigned mode, channel accumulation, bias and activation, and a fixed 4-cycle pipeline with a per-group valid pulse.

---
 rtl/cnn_kernel_acc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cnn_kernel_acc.sv
// Multi-channel CNN MAC kernel: KY x KX window products, adder tree, CI-beat channel
// accumulation, bias add, optional ReLU and output saturation in a fixed 4-stage pipeline.
module cnn_kernel_acc #(
  parameter int KX       = 3,
  parameter int KY       = 3,
  parameter int CI       = 4,
  parameter int BIT_IN_F = 8,
  parameter int BIT_WIET = 8,
  parameter int BIT_BIAS = 8,
  parameter int BIT_OUT  = 16,
  parameter int SIGNED   = 0,
  parameter int RELU     = 1,
  localparam int CW      = (CI > 1) ? $clog2(CI) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_soft_reset,
  input  logic [KY*KX*BIT_WIET-1:0]    i_weight,
  input  logic [KY*KX*BIT_IN_F-1:0]    i_in_FM,
  input  logic [BIT_BIAS-1:0]          i_bias,
  input  logic                         i_in_valid,
  output logic [CW-1:0]                o_ch_idx,
  output logic                         o_valid,
  output logic [BIT_OUT-1:0]           o_result
);

  localparam int NK       = KX * KY;
  localparam int BIT_MUL  = BIT_IN_F + BIT_WIET;
  localparam int BIT_SUM  = BIT_MUL + $clog2(NK);
  localparam int BIT_ACC  = BIT_SUM + $clog2(CI);
  localparam int BIT_FULL = ((BIT_ACC > BIT_BIAS) ? BIT_ACC : BIT_BIAS) + 1;
  localparam int BIT_CMP  = ((BIT_FULL > BIT_OUT) ? BIT_FULL : BIT_OUT) + 1;

  localparam bit SGN        = (SIGNED != 0);
  localparam bit DO_RELU    = (SIGNED != 0) && (RELU != 0);
  localparam bit SAT_SIGNED = (SIGNED != 0) && (RELU == 0);

  localparam logic signed [BIT_CMP-1:0] UMAX = {{(BIT_CMP-BIT_OUT){1'b0}}, {BIT_OUT{1'b1}}};
  localparam logic signed [BIT_CMP-1:0] SMAX = {{(BIT_CMP-BIT_OUT+1){1'b0}}, {(BIT_OUT-1){1'b1}}};
  localparam logic signed [BIT_CMP-1:0] SMIN = {{(BIT_CMP-BIT_OUT+1){1'b1}}, {(BIT_OUT-1){1'b0}}};

  logic [CW-1:0]      ch_cnt;
  logic               accept, first_c, last_c;
  logic [BIT_MUL-1:0] mul_c [NK];
  logic [BIT_SUM-1:0] sum_c;
  logic [BIT_ACC-1:0] sum_ext_c;
  logic signed [BIT_FULL-1:0] full_c;
  logic signed [BIT_CMP-1:0]  wide_c;
  logic [BIT_OUT-1:0] res_c;

  logic               s1_valid, s1_first, s1_last;
  logic [BIT_MUL-1:0] s1_prod [NK];
  logic [BIT_BIAS-1:0] s1_bias;
  logic               s2_valid, s2_first, s2_last;
  logic [BIT_SUM-1:0] s2_sum;
  logic [BIT_BIAS-1:0] s2_bias;
  logic               s3_valid, s3_last;
  logic [BIT_ACC-1:0] acc;
  logic [BIT_BIAS-1:0] s3_bias;

  assign accept   = i_in_valid && !i_soft_reset;
  assign first_c  = (ch_cnt == '0);
  assign last_c   = (ch_cnt == CW'(CI - 1));
  assign o_ch_idx = ch_cnt;

  // Operands are widened with their sign bit (or a zero in unsigned mode) before multiplying.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      mul_c[k] = BIT_MUL'($signed({SGN & i_in_FM[k*BIT_IN_F + BIT_IN_F-1], i_in_FM[k*BIT_IN_F +: BIT_IN_F]}))
               * BIT_MUL'($signed({SGN & i_weight[k*BIT_WIET + BIT_WIET-1], i_weight[k*BIT_WIET +: BIT_WIET]}));
    end
  end

  // NOTE: every always_comb output gets a default before any conditional use, so no latch is inferred.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NK; k++) begin
      sum_c = sum_c + BIT_SUM'($signed({SGN & s1_prod[k][BIT_MUL-1], s1_prod[k]}));
    end
  end

  assign sum_ext_c = BIT_ACC'($signed({SGN & s2_sum[BIT_SUM-1], s2_sum}));
  assign full_c    = BIT_FULL'($signed({SGN & acc[BIT_ACC-1], acc}))
                   + BIT_FULL'($signed({SGN & s3_bias[BIT_BIAS-1], s3_bias}));

  always_comb begin
    wide_c = BIT_CMP'(full_c);
    if (DO_RELU && wide_c[BIT_CMP-1])              res_c = '0;
    else if (SAT_SIGNED && (wide_c > SMAX))        res_c = SMAX[BIT_OUT-1:0];
    else if (SAT_SIGNED && (wide_c < SMIN))        res_c = SMIN[BIT_OUT-1:0];
    else if (!SAT_SIGNED && (wide_c > UMAX))       res_c = UMAX[BIT_OUT-1:0];
    else if (!SAT_SIGNED && wide_c[BIT_CMP-1])     res_c = '0;
    else                                           res_c = wide_c[BIT_OUT-1:0];
  end

  // Datapath registers: loaded under their stage valid, cleared only by the async reset.
  // NOTE: the product array is a plain register bank (not a RAM), so resetting it element-wise is cheap and legal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) s1_prod[k] <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
      s2_bias  <= '0;
      s3_last  <= 1'b0;
      s3_bias  <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NK; k++) s1_prod[k] <= mul_c[k];
        s1_first <= first_c;
        s1_last  <= last_c;
        if (last_c) s1_bias <= i_bias;
      end
      if (s1_valid) begin
        s2_sum   <= sum_c;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_bias  <= s1_bias;
      end
      if (s2_valid) begin
        s3_last <= s2_last;
        s3_bias <= s2_bias;
      end
    end
  end

  // Control state; soft reset discards any partial group and in-flight results.
  // NOTE: sequential state uses non-blocking assignments so every stage reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_cnt   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      acc      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_soft_reset) begin
      ch_cnt   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      acc      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      if (accept) ch_cnt <= last_c ? '0 : ch_cnt + CW'(1);
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      // A first beat overwrites, so stage 4 still sees the finished group on this edge.
      if (s2_valid) acc <= s2_first ? sum_ext_c : acc + sum_ext_c;
      o_valid <= s3_valid && s3_last;
      if (s3_valid && s3_last) o_result <= res_c;
    end
  end

endmodule
